median_filter_ctrl: RTL and testbench

//  Line sequencer for the 9-tap 1-D median_filter: accepts a pixel line stream (s_val/s_rdy),

---
 rtl/mf_pkg.sv | 17 +
 rtl/mf_tag_delay.sv | 36 +++
 rtl/median_filter_ctrl.sv | 162 ++++++++++++++++
 tb/tb_median_filter_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mf_pkg.sv
// Shared constants and types for the median filter line sequencer.
// Window geometry is fixed by TAPS; PAD samples are injected on each side of a line.
package mf_pkg;

  localparam int TAPS = 9;
  localparam int PAD  = (TAPS - 1) / 2;
  localparam int DISC = 2 * PAD;

  typedef enum logic [1:0] {IDLE, LEAD, PASS, TAIL} state_t;

  typedef struct packed {
    logic v;
    logic keep;
    logic eol;
  } tag_t;

endpackage

// File: rtl/mf_tag_delay.sv
// Fixed-depth shift register carrying sample tags alongside the free-running filter.
// Cleared asynchronously so that outputs of an aborted line are never tagged valid.
module mf_tag_delay
  import mf_pkg::*;
#(
  parameter int DEPTH = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_any_v
);

  logic [DEPTH-1:0] w_v;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    tag_t r_q;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= i_tag;
      end
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= g_stage[gi-1].r_q;
      end
    end
    assign w_v[gi] = r_q.v;
  end

  assign o_tag   = g_stage[DEPTH-1].r_q;
  assign o_any_v = |w_v;

endmodule

// File: rtl/median_filter_ctrl.sv
// Line sequencer for a 9-tap median filter: pads each line, feeds the filter gaplessly
// and re-tags the filter's free-running output so exactly N medians leave per line.
module median_filter_ctrl
  import mf_pkg::*;
#(
  parameter int MF_LAT   = 14,
  parameter int PAD_MODE = 0,
  parameter int LEN_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] s_dat,
  input  logic       s_val,
  input  logic       s_eol,
  output logic       s_rdy,
  output logic [7:0] mf_dat_o,
  output logic       mf_val_o,
  input  logic [7:0] mf_dat_i,
  input  logic       mf_val_i,
  output logic [7:0] m_dat,
  output logic       m_val,
  output logic       m_eol,
  output logic       busy,
  output logic       err_gap,
  output logic       err_sync
);

  state_t           r_state;
  logic [LEN_W-1:0] r_pad_cnt;
  logic [LEN_W-1:0] r_smp_cnt;
  logic [7:0]       r_edge;
  logic [7:0]       r_last;
  tag_t             r_tag;
  logic             r_s_rdy;
  logic [7:0]       r_mf_dat;
  logic             r_mf_val;
  logic [7:0]       r_m_dat;
  logic             r_m_val;
  logic             r_m_eol;
  logic             r_err_gap;
  logic             r_err_sync;

  logic             w_start;
  logic             w_pad_last;
  logic             w_keep;
  logic [LEN_W-1:0] w_smp_inc;
  logic [7:0]       w_pad_dat;
  tag_t             w_tag_out;
  logic             w_inflight;
  logic             w_exit_v;

  assign w_start    = en & s_val;
  assign w_pad_last = (r_pad_cnt == LEN_W'(PAD - 1));
  // Only samples whose window lies entirely inside the padded line produce a median.
  assign w_keep     = (r_smp_cnt >= LEN_W'(DISC));
  assign w_smp_inc  = (&r_smp_cnt) ? r_smp_cnt : r_smp_cnt + 1'b1;
  assign w_pad_dat  = (PAD_MODE == 0) ? 8'd0 : ((r_state == LEAD) ? r_edge : r_last);
  assign w_exit_v   = w_tag_out.v & w_tag_out.keep & mf_val_i;

  mf_tag_delay #(.DEPTH(MF_LAT)) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_tag   (r_tag),
    .o_tag   (w_tag_out),
    .o_any_v (w_inflight)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pad_cnt  <= '0;
      r_smp_cnt  <= '0;
      r_edge     <= '0;
      r_last     <= '0;
      r_tag      <= '0;
      r_s_rdy    <= 1'b0;
      r_mf_dat   <= '0;
      r_mf_val   <= 1'b0;
      r_m_dat    <= '0;
      r_m_val    <= 1'b0;
      r_m_eol    <= 1'b0;
      r_err_gap  <= 1'b0;
      r_err_sync <= 1'b0;
    end else begin
      r_mf_val <= 1'b0;
      r_tag    <= '0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= LEAD;
            r_pad_cnt <= '0;
            r_smp_cnt <= '0;
            r_edge    <= s_dat;
          end
        end
        LEAD: begin
          r_mf_val  <= 1'b1;
          r_mf_dat  <= w_pad_dat;
          r_tag     <= '{v: 1'b1, keep: w_keep, eol: 1'b0};
          r_smp_cnt <= w_smp_inc;
          r_pad_cnt <= r_pad_cnt + 1'b1;
          if (w_pad_last) begin
            r_state <= PASS;
            r_s_rdy <= 1'b1;
          end
        end
        PASS: begin
          if (s_val) begin
            r_mf_val  <= 1'b1;
            r_mf_dat  <= s_dat;
            r_last    <= s_dat;
            r_tag     <= '{v: 1'b1, keep: w_keep, eol: 1'b0};
            r_smp_cnt <= w_smp_inc;
            if (s_eol) begin
              r_state   <= TAIL;
              r_s_rdy   <= 1'b0;
              r_pad_cnt <= '0;
            end
          end else begin
            r_err_gap <= 1'b1;
          end
        end
        TAIL: begin
          r_mf_val  <= 1'b1;
          r_mf_dat  <= w_pad_dat;
          r_tag     <= '{v: 1'b1, keep: w_keep, eol: w_pad_last};
          r_smp_cnt <= w_smp_inc;
          r_pad_cnt <= r_pad_cnt + 1'b1;
          if (w_pad_last) begin
            // Chain straight into the next line's lead pads so the filter sees no bubble.
            if (w_start) begin
              r_state   <= LEAD;
              r_pad_cnt <= '0;
              r_smp_cnt <= '0;
              r_edge    <= s_dat;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      r_m_val <= w_exit_v;
      r_m_eol <= w_exit_v & w_tag_out.eol;
      r_m_dat <= mf_dat_i;
      if (w_tag_out.v != mf_val_i) r_err_sync <= 1'b1;
    end
  end

  assign s_rdy    = r_s_rdy;
  assign mf_dat_o = r_mf_dat;
  assign mf_val_o = r_mf_val;
  assign m_dat    = r_m_dat;
  assign m_val    = r_m_val;
  assign m_eol    = r_m_eol;
  assign busy     = (r_state != IDLE) | r_tag.v | w_inflight;
  assign err_gap  = r_err_gap;
  assign err_sync = r_err_sync;

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Directed bench: two controllers (zero pad, replicate pad) share one pixel stream,
// each driving a behavioural 9-tap median filter with 14-cycle latency.
module tb_median_filter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tb_init = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s_dat = 8'd0;
  logic       s_val = 1'b0;
  logic       s_eol = 1'b0;

  logic       s_rdy_w    [2];
  logic [7:0] mf_dat_o_w [2];
  logic       mf_val_o_w [2];
  logic [7:0] mf_dat_i_w [2];
  logic       mf_val_i_w [2];
  logic [7:0] m_dat_w    [2];
  logic       m_val_w    [2];
  logic       m_eol_w    [2];
  logic       busy_w     [2];
  logic       err_gap_w  [2];
  logic       err_sync_w [2];

  logic [71:0] win  [2];
  logic [13:0] pval [2];
  logic [7:0]  pdat [2][14];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic       mon_clr = 1'b0;
  logic [7:0] out_dat [2][64];
  logic       out_eol [2][64];
  int         out_n [2];
  int         eol_n [2];
  int         first_cyc [2];
  int         mf_n, first_mf, last_mf;

  logic [7:0] lbuf [64];
  int         acc0, acc_eol;
  int         exp_rep [5] = '{10, 20, 30, 30, 30};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    median_filter_ctrl #(.MF_LAT(14), .PAD_MODE(gi), .LEN_W(12)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .s_dat    (s_dat),
      .s_val    (s_val),
      .s_eol    (s_eol),
      .s_rdy    (s_rdy_w[gi]),
      .mf_dat_o (mf_dat_o_w[gi]),
      .mf_val_o (mf_val_o_w[gi]),
      .mf_dat_i (mf_dat_i_w[gi]),
      .mf_val_i (mf_val_i_w[gi]),
      .m_dat    (m_dat_w[gi]),
      .m_val    (m_val_w[gi]),
      .m_eol    (m_eol_w[gi]),
      .busy     (busy_w[gi]),
      .err_gap  (err_gap_w[gi]),
      .err_sync (err_sync_w[gi])
    );
    assign mf_val_i_w[gi] = pval[gi][13];
    assign mf_dat_i_w[gi] = pdat[gi][13];
  end

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] t [9];
    logic [7:0] x;
    for (int k = 0; k < 9; k++) t[k] = w[k*8 +: 8];
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8 - a; b++)
        if (t[b] > t[b+1]) begin
          x = t[b]; t[b] = t[b+1]; t[b+1] = x;
        end
    return t[4];
  endfunction

  // Behavioural filter: free-running, shifts a zero on bubbles, not reset by rst_n.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tb_init) begin
        win[i]  <= '0;
        pval[i] <= '0;
      end else begin
        win[i]     <= {win[i][63:0], (mf_val_o_w[i] ? mf_dat_o_w[i] : 8'd0)};
        pval[i]    <= {pval[i][12:0], mf_val_o_w[i]};
        pdat[i][0] <= med9({win[i][63:0], (mf_val_o_w[i] ? mf_dat_o_w[i] : 8'd0)});
        for (int s = 13; s > 0; s--) pdat[i][s] <= pdat[i][s-1];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 2; i++) begin
        out_n[i] = 0; eol_n[i] = 0; first_cyc[i] = -1;
      end
      mf_n = 0; first_mf = -1; last_mf = -1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_val_w[i] && out_n[i] < 64) begin
          if (out_n[i] == 0) first_cyc[i] = cyc;
          out_dat[i][out_n[i]] = m_dat_w[i];
          out_eol[i][out_n[i]] = m_eol_w[i];
          $display("out dut%0d #%0d dat=%0d eol=%0d cyc=%0d", i, out_n[i], m_dat_w[i], m_eol_w[i], cyc);
          out_n[i]++;
        end
        if (m_eol_w[i]) eol_n[i]++;
      end
      if (mf_val_o_w[0]) begin
        if (mf_n == 0) first_mf = cyc;
        last_mf = cyc;
        mf_n++;
      end
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic drive_line(input int off, input int n, input int gap_k, input int enoff_k, input bit hold);
    int t;
    bit timeout;
    timeout = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_k) begin
        s_val = 1'b0;
        @(negedge clk);
      end
      if (k == enoff_k) en = 1'b0;
      s_val = 1'b1;
      s_dat = lbuf[off + k];
      s_eol = (k == n - 1);
      t = 0;
      while (!s_rdy_w[0] && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) timeout = 1'b1;
      if (k == 0) acc0 = cyc;
      if (k == n - 1) acc_eol = cyc;
      $display("in  pix #%0d dat=%0d eol=%0d cyc=%0d", k, lbuf[off + k], (k == n - 1), cyc);
      @(negedge clk);
    end
    if (!hold) begin
      s_val = 1'b0;
      s_eol = 1'b0;
    end
    chk("accept_in_time", timeout, 0);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while ((busy_w[0] || busy_w[1]) && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk(tag, busy_w[0] | busy_w[1], 0);
  endtask

  initial begin
    lbuf[0] = 8'd10; lbuf[1] = 8'd50; lbuf[2] = 8'd20; lbuf[3] = 8'd40; lbuf[4] = 8'd30;
    for (int k = 10; k < 19; k++) lbuf[k] = 8'd77;
    for (int k = 19; k < 28; k++) lbuf[k] = 8'd200;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_rdy",    s_rdy_w[0],    0);
    chk("rst_mf_val",   mf_val_o_w[0], 0);
    chk("rst_m_val",    m_val_w[0],    0);
    chk("rst_busy",     busy_w[0],     0);
    chk("rst_err_gap",  err_gap_w[0],  0);
    chk("rst_err_sync", err_sync_w[0], 0);
    rst_n = 1'b1;
    tb_init = 1'b0;
    repeat (2) @(negedge clk);

    // Single 5-pixel line, both pad modes
    en = 1'b1;
    clear_mon();
    drive_line(0, 5, -1, -1, 0);
    wait_idle("t1_idle");
    chk("t1_count0", out_n[0], 5);
    chk("t1_count1", out_n[1], 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t1_zero_dat%0d", k), out_dat[0][k], 10);
      chk($sformatf("t1_rep_dat%0d", k),  out_dat[1][k], exp_rep[k]);
    end
    chk("t1_eol_cnt", eol_n[0], 1);
    chk("t1_eol_pos", out_eol[0][4], 1);
    chk("t1_latency", first_cyc[0] - acc0, 20);
    chk("t1_mf_samples", mf_n, 13);
    chk("t1_lead_pads", acc0 - first_mf, 3);
    chk("t1_tail_pads", last_mf - acc_eol, 5);

    // Back-to-back 9-pixel lines
    clear_mon();
    drive_line(10, 9, -1, -1, 1);
    drive_line(19, 9, -1, -1, 0);
    wait_idle("t2_idle");
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t2_count%0d", i), out_n[i], 18);
      chk($sformatf("t2_eols%0d", i), eol_n[i], 2);
      for (int k = 0; k < 18; k++)
        chk($sformatf("t2_dat%0d_%0d", i, k), out_dat[i][k], (k < 9) ? 77 : 200);
    end
    chk("t2_eol_a", out_eol[0][8], 1);
    chk("t2_eol_b", out_eol[0][17], 1);
    chk("t2_mf_samples", mf_n, 34);
    chk("t2_mf_gapless", last_mf - first_mf + 1, 34);
    chk("t2_err_gap", err_gap_w[0], 0);
    chk("t2_err_sync0", err_sync_w[0], 0);
    chk("t2_err_sync1", err_sync_w[1], 0);

    // en low in IDLE: nothing starts
    en = 1'b0;
    clear_mon();
    s_val = 1'b1;
    s_dat = 8'd99;
    repeat (10) @(negedge clk);
    chk("t3_s_rdy", s_rdy_w[0], 0);
    chk("t3_mf_samples", mf_n, 0);
    chk("t3_busy", busy_w[0], 0);
    s_val = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_outputs", out_n[0], 0);

    // en dropped mid-line: line still completes
    en = 1'b1;
    clear_mon();
    drive_line(0, 5, -1, 2, 0);
    wait_idle("t4_idle");
    chk("t4_count", out_n[0], 5);
    chk("t4_eols", eol_n[0], 1);
    chk("t4_dat", out_dat[0][2], 10);
    en = 1'b1;

    // One-cycle source stall mid-line
    clear_mon();
    drive_line(0, 5, 2, -1, 0);
    wait_idle("t5_idle");
    chk("t5_err_gap", err_gap_w[0], 1);
    chk("t5_count", out_n[0], 5);
    chk("t5_eols", eol_n[0], 1);
    chk("t5_eol_pos", out_eol[0][4], 1);
    chk("t5_err_sync", err_sync_w[0], 0);
    clear_mon();
    drive_line(10, 9, -1, -1, 0);
    wait_idle("t5b_idle");
    chk("t5_gap_sticky", err_gap_w[0], 1);

    // Reset mid-line, then a clean line
    clear_mon();
    for (int k = 0; k < 9; k++) lbuf[30 + k] = 8'd123;
    fork
      drive_line(30, 9, -1, -1, 0);
      begin
        while (!s_rdy_w[0]) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
      end
    join_any
    disable fork;
    s_val = 1'b0;
    s_eol = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t6_busy_after_rst", busy_w[0], 0);
    chk("t6_s_rdy_after_rst", s_rdy_w[0], 0);
    chk("t6_err_gap_cleared", err_gap_w[0], 0);
    repeat (40) @(negedge clk);
    chk("t6_no_stray", out_n[0] + out_n[1], 0);
    clear_mon();
    drive_line(0, 5, -1, -1, 0);
    wait_idle("t6_idle");
    chk("t6_count", out_n[0], 5);
    chk("t6_eols", eol_n[0], 1);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t6_dat%0d", k), out_dat[0][k], 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
